dwrr_fifo_arbiter: RTL and testbench

- NUM_REQS independent FIFO queues sharing one output.
- A deficit-weighted round-robin (DWRR) arbiter selects one non-empty queue per cycle; the grant pops that queue.
- The popped head word is presented as the block output in the same cycle.
- Sits between multiple packet producers and a single consumer; used as the arbitrated datapath checked by the data-integrity scoreboard.

---
 rtl/dwrr_fifo_arbiter_if.sv | 39 +++
 rtl/dwrr_fifo_arbiter.sv | 157 +++++++++++++++
 tb/tb_dwrr_fifo_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwrr_fifo_arbiter_if.sv
// ---------------------------------------------------------------------------
// dwrr_fifo_arbiter_if
// Bundles the multi-queue write side and the arbitrated read side of
// dwrr_fifo_arbiter into one interface.
//   push           : per-queue write strobe            (producer -> arbiter)
//   flat_data_in   : per-queue write data, packed      (producer -> arbiter)
//   input_quantums : per-queue DWRR quantum, packed    (producer -> arbiter)
//   full / empty   : per-queue occupancy flags         (arbiter -> producer)
//   gnt            : one-hot (or zero) pop/grant vector
//   flat_data_out  : head word of every queue, packed
//   data_out       : head word of the granted queue, 0 when idle
//   data_out_vld   : high whenever a grant is issued
// Modports: master drives the inputs (bench/producers), slave is the arbiter.
// ---------------------------------------------------------------------------
interface dwrr_fifo_arbiter_if #(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int QWID     = 8
);
    logic [NUM_REQS-1:0]       push;
    logic [NUM_REQS*WIDTH-1:0] flat_data_in;
    logic [NUM_REQS*QWID-1:0]  input_quantums;
    logic [NUM_REQS-1:0]       full;
    logic [NUM_REQS-1:0]       empty;
    logic [NUM_REQS-1:0]       gnt;
    logic [NUM_REQS*WIDTH-1:0] flat_data_out;
    logic [WIDTH-1:0]          data_out;
    logic                      data_out_vld;

    modport master (
        output push, flat_data_in, input_quantums,
        input  full, empty, gnt, flat_data_out, data_out, data_out_vld
    );

    modport slave (
        input  push, flat_data_in, input_quantums,
        output full, empty, gnt, flat_data_out, data_out, data_out_vld
    );
endinterface

// File: rtl/dwrr_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// dwrr_fifo_arbiter
// NUM_REQS independent FIFOs sharing one output. A deficit-weighted
// round-robin arbiter grants at most one non-empty queue per cycle; the grant
// pops that queue and its head word appears on data_out in the same cycle.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears queues, deficits, pointer)
//   blk_i   : arbitration block, only present when DWRR_BLK_EN is defined;
//             otherwise blocking is tied off internally
//   bus_io  : dwrr_fifo_arbiter_if.slave (push/data/quanta in, flags/grant/
//             data out)
//
// Optional feature macro: DWRR_BLK_EN
// DEPTH must be a power of two (pointers wrap naturally); PSIZE <= 2^QWID-1.
// ---------------------------------------------------------------------------
module dwrr_fifo_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int QWID     = 8,
    parameter int PSIZE    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef DWRR_BLK_EN
    input  logic                 blk_i,
`endif
    dwrr_fifo_arbiter_if.slave   bus_io
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = QWID + 1;
    localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic blk;
`ifdef DWRR_BLK_EN
    assign blk = blk_i;
`else
    assign blk = 1'b0;
`endif

    logic [WIDTH-1:0]    mem_q     [NUM_REQS][DEPTH];
    logic [AW-1:0]       wrPtr_q   [NUM_REQS];
    logic [AW-1:0]       rdPtr_q   [NUM_REQS];
    logic [CW-1:0]       count_q   [NUM_REQS];
    logic [DW-1:0]       deficit_q [NUM_REQS];
    logic [DW-1:0]       deficit_d [NUM_REQS];
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;

    logic [NUM_REQS-1:0] fullV;
    logic [NUM_REQS-1:0] emptyV;
    logic [NUM_REQS-1:0] gntV;
    logic [NUM_REQS-1:0] pushOk;
    logic                grantOk;
    logic [PW-1:0]       nextPtr;
    logic [QWID-1:0]     quantum;
    logic [DW:0]         creditSum;

    // Occupancy flags, head words and push acceptance per queue. A full queue
    // still accepts a push in the cycle it is being popped.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            fullV[i]  = (count_q[i] == CW'(DEPTH));
            emptyV[i] = (count_q[i] == '0);
            pushOk[i] = bus_io.push[i] & (~fullV[i] | gntV[i]);
            bus_io.flat_data_out[i*WIDTH +: WIDTH] = mem_q[i][rdPtr_q[i]];
        end
    end

    // FIFO storage and pointers. Writes land in memory at the edge, so a
    // pushed word can only reach the head from the following cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
                count_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (pushOk[i]) begin
                    mem_q[i][wrPtr_q[i]] <= bus_io.flat_data_in[i*WIDTH +: WIDTH];
                    wrPtr_q[i]           <= wrPtr_q[i] + 1'b1;
                end
                if (gntV[i]) begin
                    rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
                end
                if (pushOk[i] && !gntV[i]) begin
                    count_q[i] <= count_q[i] + 1'b1;
                end else if (gntV[i] && !pushOk[i]) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
            end
        end
    end

    // Grant: only the queue under the round-robin pointer may be served, and
    // only if it has data and enough deficit to pay for one word.
    always_comb begin
        grantOk = ~blk & ~emptyV[ptr_q] & (deficit_q[ptr_q] >= DW'(PSIZE));
        gntV    = '0;
        if (grantOk) begin
            gntV[ptr_q] = 1'b1;
        end
    end

    // Deficit and pointer next state. When the pointer moves on, the queue it
    // lands on is credited its current quantum, saturating at the counter max.
    // An empty queue forfeits its leftover deficit; a starved-but-waiting one
    // keeps it for the next visit.
    always_comb begin
        deficit_d = deficit_q;
        ptr_d     = ptr_q;
        nextPtr   = (ptr_q == PW'(NUM_REQS - 1)) ? '0 : ptr_q + PW'(1);
        quantum   = bus_io.input_quantums[nextPtr*QWID +: QWID];
        creditSum = {1'b0, deficit_q[nextPtr]} + (DW+1)'(quantum);
        if (!blk) begin
            if (grantOk) begin
                deficit_d[ptr_q] = deficit_q[ptr_q] - DW'(PSIZE);
            end else begin
                if (emptyV[ptr_q]) begin
                    deficit_d[ptr_q] = '0;
                end
                ptr_d              = nextPtr;
                deficit_d[nextPtr] = creditSum[DW] ? '1 : creditSum[DW-1:0];
            end
        end
    end

    // Arbiter state registers; the pointer starts on the last queue so the
    // first cycle out of reset moves to queue 0 and credits it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(NUM_REQS - 1);
            for (int i = 0; i < NUM_REQS; i++) begin
                deficit_q[i] <= '0;
            end
        end else if (!blk) begin
            ptr_q     <= ptr_d;
            deficit_q <= deficit_d;
        end
    end

    assign bus_io.full         = fullV;
    assign bus_io.empty        = emptyV;
    assign bus_io.gnt          = gntV;
    assign bus_io.data_out_vld = grantOk;
    assign bus_io.data_out     = grantOk ? mem_q[ptr_q][rdPtr_q[ptr_q]] : '0;

endmodule

// File: tb/tb_dwrr_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dwrr_fifo_arbiter
// Directed bench for dwrr_fifo_arbiter. A per-queue scoreboard holds the words
// expected in each FIFO and a small DWRR reference model predicts the grant
// every cycle; scenario-level checks confirm the scheduling patterns.
// ---------------------------------------------------------------------------
module tb_dwrr_fifo_arbiter;

    localparam int NUM_REQS = 4;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int QWID     = 8;
    localparam int PSIZE    = 8;
    localparam int DEFMAX   = (1 << (QWID + 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic blk = 1'b0;

    always #5 clk = ~clk;

    dwrr_fifo_arbiter_if #(.NUM_REQS(NUM_REQS), .WIDTH(WIDTH), .QWID(QWID)) bus ();

    dwrr_fifo_arbiter #(
        .NUM_REQS (NUM_REQS),
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .QWID     (QWID),
        .PSIZE    (PSIZE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef DWRR_BLK_EN
        .blk_i  (blk),
`endif
        .bus_io (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [NUM_REQS-1:0] pushV;
    logic [WIDTH-1:0]    dinV   [NUM_REQS];
    logic [QWID-1:0]     quantV [NUM_REQS];

    logic [WIDTH-1:0] sbq [NUM_REQS][$];
    int mDef [NUM_REQS];
    int mPtr;
    int cycleNo = 0;

    int gntLog [$];
    int cycLog [$];
    logic [WIDTH-1:0] dataLog [$];

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the current stimulus variables onto the interface.
    task automatic applyStimulus();
        bus.push = pushV;
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.flat_data_in[i*WIDTH +: WIDTH]  = dinV[i];
            bus.input_quantums[i*QWID +: QWID]  = quantV[i];
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REQS; i++) begin
            sbq[i].delete();
            mDef[i] = 0;
        end
        mPtr = NUM_REQS - 1;
    endtask

    // One clock cycle: drive, check outputs against the model mid-cycle,
    // advance the model, then step past the rising edge.
    task automatic runCycle();
        logic [NUM_REQS-1:0] eg;
        logic [WIDTH-1:0]    ed;
        int sz [NUM_REQS];
        int gi;
        applyStimulus();
        @(negedge clk);
        for (int i = 0; i < NUM_REQS; i++) sz[i] = sbq[i].size();
        eg = '0;
        if (!blk && sz[mPtr] > 0 && mDef[mPtr] >= PSIZE) eg[mPtr] = 1'b1;
        ed = (eg != '0) ? sbq[mPtr][0] : '0;
        checkOutput("gnt", 32'(bus.gnt), 32'(eg));
        checkOutput("data_out_vld", 32'(bus.data_out_vld), 32'(eg != '0));
        checkOutput("data_out", 32'(bus.data_out), 32'(ed));
        for (int i = 0; i < NUM_REQS; i++) begin
            checkOutput($sformatf("empty%0d", i), 32'(bus.empty[i]), 32'(sz[i] == 0));
            checkOutput($sformatf("full%0d", i), 32'(bus.full[i]), 32'(sz[i] == DEPTH));
            if (sz[i] > 0)
                checkOutput($sformatf("head%0d", i), 32'(bus.flat_data_out[i*WIDTH +: WIDTH]), 32'(sbq[i][0]));
        end
        if (bus.gnt != '0) begin
            gi = 0;
            for (int i = 0; i < NUM_REQS; i++) if (bus.gnt[i]) gi = i;
            gntLog.push_back(gi);
            cycLog.push_back(cycleNo);
            dataLog.push_back(bus.data_out);
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (eg[i]) void'(sbq[i].pop_front());
            if (pushV[i] && (sz[i] < DEPTH || eg[i])) sbq[i].push_back(dinV[i]);
        end
        if (!blk) begin
            if (eg != '0) begin
                mDef[mPtr] -= PSIZE;
            end else begin
                if (sz[mPtr] == 0) mDef[mPtr] = 0;
                mPtr = (mPtr + 1) % NUM_REQS;
                mDef[mPtr] += int'(quantV[mPtr]);
                if (mDef[mPtr] > DEFMAX) mDef[mPtr] = DEFMAX;
            end
        end
        @(posedge clk);
        #1;
        cycleNo++;
        pushV = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) runCycle();
    endtask

    task automatic setQuanta(input int q0, input int q1, input int q2, input int q3);
        quantV[0] = QWID'(q0);
        quantV[1] = QWID'(q1);
        quantV[2] = QWID'(q2);
        quantV[3] = QWID'(q3);
    endtask

    task automatic clearLogs();
        gntLog.delete();
        cycLog.delete();
        dataLog.delete();
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int viol;
        int seqA [12];
        int seqB [12];
        bit matchA;
        bit matchB;
        seqA = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        seqB = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1};

        pushV = '0;
        for (int i = 0; i < NUM_REQS; i++) dinV[i] = '0;
        setQuanta(8, 8, 8, 8);
        applyStimulus();
        modelReset();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_empty", 32'(bus.empty), 32'hF);
        checkOutput("rst_full", 32'(bus.full), 32'h0);
        checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("rst_vld", 32'(bus.data_out_vld), 32'h0);
        checkOutput("rst_data", 32'(bus.data_out), 32'h0);
        rst_n = 1'b1;

        // Single word into queue 0: granted on the second cycle
        $display("[TB] single word into queue 0");
        pushV = 4'b0001;
        dinV[0] = 8'hA5;
        runCycle();
        checkOutput("first_gnt", 32'(bus.gnt), 32'h1);
        checkOutput("first_data", 32'(bus.data_out), 32'hA5);
        checkOutput("first_vld", 32'(bus.data_out_vld), 32'h1);
        runCycle();
        checkOutput("first_empty0", 32'(bus.empty[0]), 32'h1);
        idle(6);

        // Fill queue 1 while its quantum is 0, overflow once, then drain
        $display("[TB] fill queue 1 with zero quantum");
        setQuanta(8, 0, 8, 8);
        idle(6);
        for (int k = 0; k < 9; k++) begin
            pushV = 4'b0010;
            dinV[1] = WIDTH'(8'h10 + k);
            runCycle();
            if (k == 7) checkOutput("full1_after8", 32'(bus.full[1]), 32'h1);
        end
        checkOutput("full1_after9", 32'(bus.full[1]), 32'h1);
        clearLogs();
        setQuanta(8, 8, 8, 8);
        idle(45);
        checkOutput("q1_drain_count", 32'(gntLog.size()), 32'd8);
        for (int k = 0; k < 8 && k < dataLog.size(); k++)
            checkOutput($sformatf("q1_order%0d", k), 32'(dataLog[k]), 32'(8'h10 + k));

        // All queues loaded with 4 words, equal quanta: strict rotation
        $display("[TB] equal quanta rotation");
        setQuanta(0, 0, 0, 0);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            pushV = 4'b1111;
            for (int i = 0; i < NUM_REQS; i++) dinV[i] = WIDTH'((i << 4) | k);
            runCycle();
        end
        clearLogs();
        setQuanta(8, 8, 8, 8);
        idle(40);
        checkOutput("rot_count", 32'(gntLog.size()), 32'd16);
        viol = 0;
        for (int k = 1; k < gntLog.size(); k++)
            if (gntLog[k] != (gntLog[0] + k) % NUM_REQS) viol++;
        for (int k = 0; k < dataLog.size(); k++) begin
            if (int'(dataLog[k][7:4]) != gntLog[k]) viol++;
            if (int'(dataLog[k][3:0]) != k / NUM_REQS) viol++;
        end
        checkOutput("rot_pattern", 32'(viol), 32'd0);

        // Weighted quanta 16/8: queue 0 gets two words per visit
        $display("[TB] weighted quanta 16/8");
        setQuanta(0, 0, 0, 0);
        idle(6);
        for (int k = 0; k < 6; k++) begin
            pushV = 4'b0011;
            dinV[0] = WIDTH'(8'h40 + k);
            dinV[1] = WIDTH'(8'h50 + k);
            runCycle();
        end
        clearLogs();
        setQuanta(16, 8, 0, 0);
        idle(45);
        checkOutput("wt_count", 32'(gntLog.size()), 32'd12);
        matchA = (gntLog.size() == 12);
        matchB = (gntLog.size() == 12);
        for (int k = 0; k < 12 && k < gntLog.size(); k++) begin
            if (gntLog[k] != seqA[k]) matchA = 1'b0;
            if (gntLog[k] != seqB[k]) matchB = 1'b0;
        end
        checkOutput("wt_pattern", 32'(matchA | matchB), 32'h1);

        // Quantum below word cost: queue 2 served every second visit
        $display("[TB] quantum 4 on queue 2");
        setQuanta(0, 0, 0, 0);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            pushV = 4'b0100;
            dinV[2] = WIDTH'(8'h60 + k);
            runCycle();
        end
        clearLogs();
        setQuanta(0, 0, 4, 0);
        idle(45);
        checkOutput("q4_count", 32'(gntLog.size()), 32'd4);
        for (int k = 1; k < cycLog.size(); k++)
            checkOutput($sformatf("q4_gap%0d", k), 32'(cycLog[k] - cycLog[k-1]), 32'd9);

`ifdef DWRR_BLK_EN
        // Blocked arbitration: no grants, pushes still land, resume in place
        $display("[TB] blocked arbitration");
        setQuanta(8, 8, 8, 8);
        idle(6);
        clearLogs();
        blk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 2) begin
                pushV = 4'b1111;
                for (int i = 0; i < NUM_REQS; i++) dinV[i] = WIDTH'(8'h70 + (i << 1) + k);
            end
            runCycle();
            checkOutput($sformatf("blk_gnt%0d", k), 32'(bus.gnt), 32'h0);
        end
        checkOutput("blk_pushed", 32'(bus.empty), 32'h0);
        checkOutput("blk_no_grants", 32'(gntLog.size()), 32'd0);
        blk = 1'b0;
        idle(25);
        checkOutput("blk_resume_count", 32'(gntLog.size()), 32'd8);
`endif

        // Reset in the middle of traffic drops everything at once
        $display("[TB] mid-run reset");
        setQuanta(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            pushV = 4'b1111;
            for (int i = 0; i < NUM_REQS; i++) dinV[i] = WIDTH'(8'h80 + k);
            runCycle();
        end
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_empty", 32'(bus.empty), 32'hF);
        checkOutput("midrst_gnt", 32'(bus.gnt), 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        setQuanta(8, 8, 8, 8);
        pushV = 4'b0001;
        dinV[0] = 8'h5A;
        runCycle();
        checkOutput("post_rst_gnt", 32'(bus.gnt), 32'h1);
        checkOutput("post_rst_data", 32'(bus.data_out), 32'h5A);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
